// File: rtl/ooo_pkg.sv
// Shared out-of-order front-end types.
// Imported by the instruction queue and by rename/dispatch.
package ooo_pkg;

  localparam int IQ_DEPTH = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master: fetch + decode side, slave: the queue itself.
interface instr_queue_if #(
  parameter int DEPTH = 16
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          enqueue;
  logic [31:0]   instr_in;
  logic [31:0]   pc_in;
  logic [31:0]   pc_next_in;
  logic          iq_full;
  logic          dequeue;
  logic          iq_empty;
  logic [31:0]   instr_out;
  logic [31:0]   pc_out;
  logic [31:0]   pc_next_out;
  logic [CW-1:0] count;

  modport master (
    output flush,
    output enqueue,
    output instr_in,
    output pc_in,
    output pc_next_in,
    output dequeue,
    input  iq_full,
    input  iq_empty,
    input  instr_out,
    input  pc_out,
    input  pc_next_out,
    input  count
  );

  modport slave (
    input  flush,
    input  enqueue,
    input  instr_in,
    input  pc_in,
    input  pc_next_in,
    input  dequeue,
    output iq_full,
    output iq_empty,
    output instr_out,
    output pc_out,
    output pc_next_out,
    output count
  );

endinterface

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode.
// FWFT head, wrap-bit pointers, flush clears pointers only.
module instr_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  instr_queue_if.slave  iq
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          empty;
  logic          full;
  logic          do_enq;
  logic          do_deq;
  iq_entry_t     mem [DEPTH];
  iq_entry_t     wr_ent;
  iq_entry_t     hd_ent;

  // status comes from registered pointers only
  assign empty = (head == tail);
  assign full  = (head[IW-1:0] == tail[IW-1:0]) &&
                 (head[IW] != tail[IW]);

  assign do_enq = iq.enqueue && !full;
  assign do_deq = iq.dequeue && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (iq.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_enq) tail <= tail + PW'(1);
      if (do_deq) head <= head + PW'(1);
    end
  end

  assign wr_ent.instr   = iq.instr_in;
  assign wr_ent.pc      = iq.pc_in;
  assign wr_ent.pc_next = iq.pc_next_in;

  // no reset on storage so it can map to RAM
  always_ff @(posedge clk) begin
    if (do_enq && !iq.flush)
      mem[tail[IW-1:0]] <= wr_ent;
  end

  assign hd_ent = mem[head[IW-1:0]];

  assign iq.instr_out   = hd_ent.instr;
  assign iq.pc_out      = hd_ent.pc;
  assign iq.pc_next_out = hd_ent.pc_next;
  assign iq.iq_empty    = empty;
  assign iq.iq_full     = full;
  assign iq.count       = tail - head;

endmodule
